// File: rtl/viterbi_pkg.sv
// Shared Viterbi datapath constants and the scheduler state encoding.
// Imported by the ACS scheduler, its group counter and the BMC/ACS blocks.
package viterbi_pkg;

  localparam int unsigned NUM_STATES = 64;  // 2^(K-1) trellis states
  localparam int unsigned PAR        = 8;   // states updated per cycle by the ACS array
  localparam int unsigned G          = NUM_STATES / PAR;  // ACS groups per stage
  localparam int unsigned GRP_W      = (G > 1) ? $clog2(G) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StWait
  } acs_state_e;

endpackage

// File: rtl/bmc_acs_grp_cnt.sv
// Group index counter and ACS write-back latency counter for one trellis stage.
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   start      pair accepted; restart group index at 0
//   run        scheduler in RUN; advance group index
//   waiting    scheduler in WAIT; count down write-back latency
//   grp_idx    state group currently being updated
//   grp_last   grp_idx is the final group of the stage
//   wait_zero  write-back latency fully elapsed
module bmc_acs_grp_cnt
  import viterbi_pkg::*;
#(
  parameter int unsigned ACS_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             run,
  input  logic             waiting,
  output logic [GRP_W-1:0] grp_idx,
  output logic             grp_last,
  output logic             wait_zero
);

  // The counter holds remaining WAIT cycles minus one, so the stage commits on the
  // edge that leaves the final WAIT cycle and stage_done lands 1+G+ACS_LAT after accept.
  localparam logic [2:0] WaitInit = (ACS_LAT == 0) ? 3'd0 : 3'(ACS_LAT - 1);

  logic [2:0] wait_cnt_q;

  assign grp_last  = (grp_idx == GRP_W'(G - 1));
  assign wait_zero = (wait_cnt_q == 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      grp_idx    <= '0;
      wait_cnt_q <= '0;
    end else begin
      if (start) begin
        grp_idx <= '0;
      end else if (run) begin
        grp_idx <= grp_last ? '0 : grp_idx + GRP_W'(1);
      end

      if (run && grp_last) begin
        wait_cnt_q <= WaitInit;
      end else if (waiting && !wait_zero) begin
        wait_cnt_q <= wait_cnt_q - 3'd1;
      end
    end
  end

endmodule

// File: rtl/bmc_acs_sched.sv
// Folded Viterbi BMC/ACS stage scheduler: accepts one received pair per trellis stage,
// holds it for the shared BMC units, steps the ACS group index across all states,
// ping-pongs the path-metric banks and applies pending metric normalisation.
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   in_valid/in_ready         pair handshake from the depuncture stage
//   in_rx_pair, in_last       hard-decision pair, last-of-frame flag
//   norm_req                  ACS array requests normalisation (level, sticky-captured)
//   rx_pair_q                 pair held for all BMC units
//   acs_en, grp_idx           ACS group update strobe and group index
//   pm_rd_bank                path-metric read bank (write bank is its complement)
//   norm_en                   subtract normalisation constant this stage
//   stage_done, frame_done    one-cycle commit pulses
//   stage_cnt                 stages completed in the current frame
module bmc_acs_sched
  import viterbi_pkg::*;
#(
  parameter int unsigned ACS_LAT = 2,
  parameter int unsigned STG_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_rx_pair,
  input  logic             in_last,
  input  logic             norm_req,
  output logic [1:0]       rx_pair_q,
  output logic             acs_en,
  output logic [GRP_W-1:0] grp_idx,
  output logic             pm_rd_bank,
  output logic             norm_en,
  output logic             stage_done,
  output logic             frame_done,
  output logic [STG_W-1:0] stage_cnt
);

  localparam bit NoWait = (ACS_LAT == 0);

  acs_state_e state_q;
  logic       last_q;
  logic       norm_pend_q;
  logic       grp_last;
  logic       wait_zero;
  logic       accept;
  logic       stage_end;

  assign accept    = (state_q == StIdle) && in_valid;
  // With zero latency the stage commits straight out of RUN and WAIT is never entered.
  assign stage_end = ((state_q == StRun) && grp_last && NoWait) ||
                     ((state_q == StWait) && wait_zero);

  bmc_acs_grp_cnt #(
    .ACS_LAT (ACS_LAT)
  ) u_grp_cnt (
    .clk       (clk),
    .rst       (rst),
    .start     (accept),
    .run       (state_q == StRun),
    .waiting   (state_q == StWait),
    .grp_idx   (grp_idx),
    .grp_last  (grp_last),
    .wait_zero (wait_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready    <= 1'b1;
      rx_pair_q   <= 2'b00;
      acs_en      <= 1'b0;
      pm_rd_bank  <= 1'b0;
      norm_en     <= 1'b0;
      stage_done  <= 1'b0;
      frame_done  <= 1'b0;
      stage_cnt   <= '0;
      last_q      <= 1'b0;
      norm_pend_q <= 1'b0;
    end else begin
      stage_done  <= 1'b0;
      frame_done  <= 1'b0;
      norm_pend_q <= norm_pend_q | norm_req;

      case (state_q)
        StIdle: begin
          if (accept) begin
            rx_pair_q   <= in_rx_pair;
            last_q      <= in_last;
            norm_en     <= norm_pend_q;
            // A request seen in the accept cycle belongs to the following stage.
            norm_pend_q <= norm_req;
            in_ready    <= 1'b0;
            acs_en      <= 1'b1;
            state_q     <= StRun;
          end
        end
        StRun: begin
          if (grp_last) begin
            acs_en <= 1'b0;
            if (!NoWait) begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
        end
        default: state_q <= StIdle;
      endcase

      if (stage_end) begin
        stage_done <= 1'b1;
        norm_en    <= 1'b0;
        in_ready   <= 1'b1;
        state_q    <= StIdle;
        if (last_q) begin
          frame_done <= 1'b1;
          stage_cnt  <= '0;
          pm_rd_bank <= 1'b0;
        end else begin
          stage_cnt  <= stage_cnt + STG_W'(1);
          pm_rd_bank <= ~pm_rd_bank;
        end
      end
    end
  end

endmodule

// File: tb/tb_bmc_acs_sched.sv
module tb_bmc_acs_sched;

  localparam int G   = 8;  // 64 states / 8 per cycle
  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, in_last, norm_req;
  logic [1:0]  in_rx_pair, rx_pair_q;
  logic        acs_en, pm_rd_bank, norm_en, stage_done, frame_done;
  logic [2:0]  grp_idx;
  logic [15:0] stage_cnt;

  logic        in_valid0, in_ready0, in_last0;
  logic [1:0]  in_rx_pair0, rx_pair_q0;
  logic        acs_en0, pm_rd_bank0, norm_en0, stage_done0, frame_done0;
  logic [2:0]  grp_idx0;
  logic [15:0] stage_cnt0;

  bmc_acs_sched #(.ACS_LAT(LAT), .STG_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rx_pair(in_rx_pair), .in_last(in_last), .norm_req(norm_req),
    .rx_pair_q(rx_pair_q), .acs_en(acs_en), .grp_idx(grp_idx),
    .pm_rd_bank(pm_rd_bank), .norm_en(norm_en), .stage_done(stage_done),
    .frame_done(frame_done), .stage_cnt(stage_cnt)
  );

  bmc_acs_sched #(.ACS_LAT(0), .STG_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_rx_pair(in_rx_pair0), .in_last(in_last0), .norm_req(1'b0),
    .rx_pair_q(rx_pair_q0), .acs_en(acs_en0), .grp_idx(grp_idx0),
    .pm_rd_bank(pm_rd_bank0), .norm_en(norm_en0), .stage_done(stage_done0),
    .frame_done(frame_done0), .stage_cnt(stage_cnt0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  pair;
    logic        last;
    logic        norm;
    logic        bank;
    logic        bank_after;
    logic [15:0] cnt_after;
    int          acc;
  } stg_t;

  typedef struct {
    logic [1:0]  pair;
    logic        last;
    logic        pulse;
    logic        exp_norm;
    logic        exp_bank;
    logic [15:0] exp_cnt;
    logic        exp_fd;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          m_left = 0;
  logic        m_pend = 1'b0;
  logic        m_bank = 1'b0;
  logic [15:0] m_cnt = '0;
  logic        m_bank_vis = 1'b0;
  logic [15:0] m_cnt_vis = '0;
  bit          last_acc;
  int          seen_stages = 0;
  int          seen_frames = 0;
  stg_t        sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  // Advance one clock: update the model from the inputs driven this cycle, then
  // check the DUT outputs of the new cycle.
  task automatic cycle();
    bit   was_rst;
    stg_t e;
    int   rel;
    was_rst  = rst;
    last_acc = !rst && in_valid && (m_left == 0);
    if (rst) begin
      sb.delete();
      m_left = 0; m_pend = 0; m_bank = 0; m_cnt = '0; m_bank_vis = 0; m_cnt_vis = '0;
    end else if (last_acc) begin
      e.pair = in_rx_pair; e.last = in_last; e.norm = m_pend; e.bank = m_bank;
      m_pend = norm_req;
      if (in_last) begin
        m_bank = 1'b0; m_cnt = '0;
      end else begin
        m_bank = ~m_bank; m_cnt = m_cnt + 16'd1;
      end
      e.bank_after = m_bank; e.cnt_after = m_cnt; e.acc = cyc;
      sb.push_back(e);
      m_left = G + LAT;
    end else begin
      m_pend = m_pend | norm_req;
      if (m_left > 0) m_left--;
    end

    @(posedge clk);
    #1;
    cyc++;
    if (stage_done === 1'b1) seen_stages++;
    if (frame_done === 1'b1) seen_frames++;

    if (was_rst) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_rx_pair_q", rx_pair_q, 0);
      chk("rst_acs_en", acs_en, 0);
      chk("rst_grp_idx", grp_idx, 0);
      chk("rst_bank", pm_rd_bank, 0);
      chk("rst_norm_en", norm_en, 0);
      chk("rst_stage_done", stage_done, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_stage_cnt", stage_cnt, 0);
      return;
    end

    chk("in_ready", in_ready, (m_left == 0) ? 1 : 0);
    if (sb.size() > 0) begin
      e   = sb[0];
      rel = cyc - e.acc;
      chk("acs_en", acs_en, (rel <= G) ? 1 : 0);
      chk("grp_idx", grp_idx, (rel <= G) ? rel - 1 : 0);
      chk("rx_pair_q", rx_pair_q, e.pair);
      chk("stage_done", stage_done, (rel == G + LAT + 1) ? 1 : 0);
      if (rel == G + LAT + 1) begin
        chk("done_norm_en", norm_en, 0);
        chk("done_bank", pm_rd_bank, e.bank_after);
        chk("done_stage_cnt", stage_cnt, e.cnt_after);
        chk("done_frame_done", frame_done, e.last);
        m_bank_vis = e.bank_after;
        m_cnt_vis  = e.cnt_after;
        void'(sb.pop_front());
      end else begin
        chk("norm_en", norm_en, e.norm);
        chk("bank", pm_rd_bank, e.bank);
        chk("frame_done", frame_done, 0);
        chk("stage_cnt", stage_cnt, m_cnt_vis);
      end
    end else begin
      chk("idle_acs_en", acs_en, 0);
      chk("idle_grp_idx", grp_idx, 0);
      chk("idle_stage_done", stage_done, 0);
      chk("idle_frame_done", frame_done, 0);
      chk("idle_norm_en", norm_en, 0);
      chk("idle_bank", pm_rd_bank, m_bank_vis);
      chk("idle_stage_cnt", stage_cnt, m_cnt_vis);
    end
  endtask

  vec_t tbl[6];

  initial begin
    logic       got_norm, got_bank, prev_acs;
    logic [2:0] prev_grp;
    int         n;

    tbl[0] = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1};
    tbl[1] = '{2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 1'b0};
    tbl[2] = '{2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, 1'b0};
    tbl[3] = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1};
    tbl[4] = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0};
    tbl[5] = '{2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0, 1'b1};

    rst = 1'b1; in_valid = 0; in_rx_pair = 0; in_last = 0; norm_req = 0;
    in_valid0 = 0; in_rx_pair0 = 0; in_last0 = 0;
    cycle();
    cycle();
    rst = 1'b0;

    // Back-to-back stages; data changes while busy must not reach rx_pair_q.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_rx_pair = tbl[i].pair; in_last = tbl[i].last; norm_req = 0;
      chk("vec_ready", in_ready, 1);
      cycle();
      in_valid = (i < 5); in_rx_pair = ~tbl[i].pair; in_last = 0;
      got_norm = 0; got_bank = 0;
      for (int r = 1; r <= G + LAT; r++) begin
        if (r == 1) begin
          got_norm = norm_en; got_bank = pm_rd_bank;
        end
        norm_req = tbl[i].pulse && (r == 5);
        cycle();
      end
      norm_req = 0;
      chk("vec_done", stage_done, 1);
      chk("vec_norm", got_norm, tbl[i].exp_norm);
      chk("vec_bank", got_bank, tbl[i].exp_bank);
      chk("vec_cnt", stage_cnt, tbl[i].exp_cnt);
      chk("vec_fd", frame_done, tbl[i].exp_fd);
    end
    in_valid = 0;
    cycle();

    // One committed non-last stage, then reset mid-RUN of the next.
    in_valid = 1; in_rx_pair = 2'b01; in_last = 0;
    cycle();
    in_valid = 0;
    repeat (G + LAT) cycle();
    cycle();
    chk("pre_rst_cnt", stage_cnt, 1);
    in_valid = 1; in_rx_pair = 2'b11; in_last = 0;
    cycle();
    in_valid = 0;
    repeat (4) cycle();
    chk("rst_at_grp4", grp_idx, 4);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (12) cycle();

    // Zero-latency build: stage_done the cycle after grp_idx 7.
    chk("lat0_ready", in_ready0, 1);
    in_valid0 = 1; in_rx_pair0 = 2'b01; in_last0 = 1;
    cycle();
    in_valid0 = 0;
    n = 1; prev_grp = 0; prev_acs = 0;
    while (n < 30 && stage_done0 !== 1'b1) begin
      prev_grp = grp_idx0; prev_acs = acs_en0;
      cycle();
      n++;
    end
    chk("lat0_done_cycle", n, G + 1);
    chk("lat0_prev_grp", prev_grp, 7);
    chk("lat0_prev_acs", prev_acs, 1);
    chk("lat0_frame_done", frame_done0, 1);
    chk("lat0_stage_cnt", stage_cnt0, 0);
    chk("lat0_rx_pair_q", rx_pair_q0, 2'b01);
    cycle();
    chk("lat0_ready_after", in_ready0, 1);

    // 200-stage frame with random valid gaps and random normalisation requests.
    seen_stages = 0; seen_frames = 0;
    for (int s = 0; s < 200; s++) begin
      in_rx_pair = 2'($urandom_range(0, 3));
      in_last    = (s == 199);
      n = 0;
      do begin
        in_valid = ($urandom_range(0, 3) != 0);
        norm_req = ($urandom_range(0, 7) == 0);
        cycle();
        n++;
      end while (!last_acc && n < 100);
      if (!last_acc) chk("rand_accept_timeout", 0, 1);
    end
    in_valid = 0; norm_req = 0;
    repeat (G + LAT + 3) cycle();
    chk("rand_stages", seen_stages, 200);
    chk("rand_frames", seen_frames, 1);
    chk("rand_cnt_end", stage_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
